param_shift_reg: RTL and testbench
==================================

PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (SHALL be >= 2).
REQ-002 Parameter CNT_W, default 4, width of the shift-count input.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset, synchronous, active-low; clock clock.
REQ-005 load_n  input  1  active-low parallel load strobe.
REQ-006 load_val  input  WIDTH  parallel load data.
REQ-007 mode  input  3  operation code, sampled on accepted start.
REQ-008 amount  input  CNT_W  number of single-bit steps, sampled on accepted start.
REQ-009 start  input  1  request to begin a multi-cycle operation.
REQ-010 serial_in  input  1  fill bit for modes SRI/SLI.
REQ-011 q  output  WIDTH  register contents.
REQ-012 serial_out  output  1  registered copy of the bit most recently shifted or rotated out.
REQ-013 busy  output  1  high while in state SHIFT; decoded from state.
REQ-014 done  output  1  one-cycle completion pulse; decoded from state DONE.

Function
REQ-015 Mode codes SHALL be: 000 HOLD, 001 LSR (fill 0), 010 ASR (fill q[WIDTH-1]), 011 LSL (fill 0), 100 ROR, 101 ROL, 110 SRI (shift right, serial_in into MSB), 111 SLI (shift left, serial_in into LSB).
REQ-016 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-017 Per-edge priority SHALL be: reset_n low > load_n low > start/step activity.
REQ-018 load_n low SHALL set q <= load_val and state <= IDLE in any state; an in-flight operation is aborted with no done pulse, and serial_out holds its value.
REQ-019 start SHALL be accepted only in IDLE or DONE with load_n high; start in SHIFT SHALL be ignored.
REQ-020 On an accepted start, mode and amount SHALL be latched, with remaining <= amount; next state is SHIFT if amount != 0, otherwise DONE.
REQ-021 In SHIFT, each edge SHALL perform exactly one step per the latched mode, decrement remaining, and update serial_out. HOLD steps leave q and serial_out unchanged.
REQ-022 Leaving SHIFT: when remaining == 1 at an edge, that edge SHALL perform the final step and move to DONE.
REQ-023 Latency: for a start accepted at edge 0 with amount N > 0, steps occur at edges 1..N, busy is high after edges 0..N-1, and done is high for exactly the cycle after edge N.
REQ-024 amount = 0: done SHALL pulse in the cycle after the start edge with q unchanged and busy never high.
REQ-025 DONE SHALL last one cycle, then go to IDLE, or to SHIFT/DONE if a new start is accepted (back-to-back operation).
REQ-026 amount > WIDTH SHALL be legal: logical shifts saturate to all-fill, rotates wrap modulo WIDTH, and ASR saturates to all sign bits.
REQ-027 Changes to mode or amount while busy SHALL have no effect.
REQ-028 serial_out SHALL be q[0] for right-direction steps and q[WIDTH-1] for left-direction steps, taken from the pre-step value.

Reset
REQ-029 On a rising clock edge with reset_n low: q = 0, serial_out = 0, state = IDLE, remaining = 0, latched mode = HOLD; therefore busy = 0 and done = 0.
REQ-030 Reset asserted mid-operation SHALL abort with no done pulse; reset overrides load_n and start.

Structure
REQ-031 Mode code constants and FSM state encodings SHALL live in the shared shift package and be used by both RTL and bench.
REQ-032 The single-step next-value logic (q, mode, serial_in -> next q, out bit) SHALL be a combinational sub-module named shift_step_unit; the FSM, counter and registers stay in param_shift_reg.

Verification (WIDTH=8, CNT_W=4)
REQ-033 Load 0x96, start ASR, amount 3 -> q 0xCB, 0xE5, 0xF2 on edges 1-3; done pulse after edge 3; serial_out = 1.
REQ-034 Load 0x81, start ROL, amount 4 -> q 0x03, 0x06, 0x0C, 0x18; serial_out = 0; busy high for exactly 4 cycles.
REQ-035 Load 0x00, serial_in = 1, start SLI, amount 8 -> q = 0xFF after edge 8; done pulses once; start pulsed during SHIFT is ignored.
REQ-036 Load 0xFF, start LSR, amount 8; after q = 0x3F, drive load_n low with load_val 0x5A -> q = 0x5A, busy = 0, no done pulse.
REQ-037 amount = 0 with any mode -> done the next cycle with q unchanged; reset_n low mid-SHIFT -> q = 0, serial_out = 0, busy = 0, done = 0.
REQ-038 Back-to-back: start LSL amount 2 on 0x01, then start again in DONE with amount 1 -> q 0x02, 0x04, then 0x08; done pulses twice.

Source files
------------

// File: rtl/param_shift_reg_pkg.sv
// param_shift_reg_pkg: shared mode codes and FSM state encodings for the shift register
package param_shift_reg_pkg;
  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LSR  = 3'b001,
    M_ASR  = 3'b010,
    M_LSL  = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_SRI  = 3'b110,
    M_SLI  = 3'b111
  } mode_t;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/param_shift_reg_step.sv
// shift_step_unit: combinational single-step next value and shifted-out bit
module shift_step_unit
  import param_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);
  logic is_right;
  logic fill_r;
  logic fill_l;
  // right-direction modes shift towards bit 0; everything else except HOLD shifts left
  always_comb begin
    is_right = mode inside {M_LSR, M_ASR, M_ROR, M_SRI};
    fill_r   = mode == M_ASR ? q[WIDTH-1] : mode == M_ROR ? q[0] : mode == M_SRI ? serial_in : 1'b0;
    fill_l   = mode == M_ROL ? q[WIDTH-1] : mode == M_SLI ? serial_in : 1'b0;
    q_next   = mode == M_HOLD ? q : is_right ? {fill_r, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill_l};
    out_bit  = is_right ? q[0] : q[WIDTH-1];
  end
endmodule

// File: rtl/param_shift_reg.sv
// param_shift_reg: multi-cycle shift/rotate register with parallel load and done pulse
module param_shift_reg
  import param_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] load_val,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);
  state_t           state;
  state_t           state_next;
  logic [2:0]       mode_r;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q_next;
  logic             out_bit;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .q        (q),
    .mode     (mode_r),
    .serial_in(serial_in),
    .q_next   (q_next),
    .out_bit  (out_bit)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_next;
  end

  // next state: load aborts, SHIFT runs until the last step, IDLE/DONE accept a start
  always_comb begin
    state_next = !load_n ? S_IDLE
               : state == S_SHIFT ? (remaining == CNT_W'(1) ? S_DONE : S_SHIFT)
               : start ? (amount != '0 ? S_SHIFT : S_DONE)
               : S_IDLE;
  end

  // datapath: load, one step per SHIFT cycle, or latch the operation on an accepted start
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q          <= '0;
      serial_out <= 1'b0;
      remaining  <= '0;
      mode_r     <= M_HOLD;
    end else if (!load_n) begin
      q <= load_val;
    end else if (state == S_SHIFT) begin
      q         <= q_next;
      remaining <= remaining - CNT_W'(1);
      if (mode_r != M_HOLD) serial_out <= out_bit;
    end else if (start) begin
      mode_r    <= mode;
      remaining <= amount;
    end
  end

  assign busy = state == S_SHIFT;
  assign done = state == S_DONE;
endmodule

// File: tb/tb_param_shift_reg.sv
// tb_param_shift_reg: directed and randomized checks of param_shift_reg against an arithmetic model
module tb_param_shift_reg;
  import param_shift_reg_pkg::*;
  localparam int W = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_n = 1'b1;
  logic [W-1:0]  load_val = '0;
  logic [2:0]    mode = M_HOLD;
  logic [CW-1:0] amount = '0;
  logic          start = 1'b0;
  logic          serial_in = 1'b0;
  logic [W-1:0]  q;
  logic          serial_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] mq = '0;
  logic         mso = 1'b0;

  param_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_n    (load_n),
    .load_val  (load_val),
    .mode      (mode),
    .amount    (amount),
    .start     (start),
    .serial_in (serial_in),
    .q         (q),
    .serial_out(serial_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] m, input logic si);
    case (m)
      M_LSR: begin mso = mq[0];   mq = mq >> 1; end
      M_ASR: begin mso = mq[0];   mq = W'($signed(mq) >>> 1); end
      M_LSL: begin mso = mq[W-1]; mq = mq << 1; end
      M_ROR: begin mso = mq[0];   mq = (mq >> 1) | (mq << (W - 1)); end
      M_ROL: begin mso = mq[W-1]; mq = (mq << 1) | (mq >> (W - 1)); end
      M_SRI: begin mso = mq[0];   mq = (mq >> 1) | (W'(si) << (W - 1)); end
      M_SLI: begin mso = mq[W-1]; mq = (mq << 1) | W'(si); end
      default: ;
    endcase
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_n = 1'b0;
    load_val = v;
    tick();
    load_n = 1'b1;
    mq = v;
    chk("load_q", q, mq);
    chk("load_so_hold", serial_out, mso);
  endtask

  task automatic do_op(input logic [2:0] m, input int n, input logic si, input bit chain);
    mode = m;
    amount = CW'(n);
    serial_in = si;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 3'($urandom);
    amount = CW'($urandom);
    for (int i = 0; i < n; i++) begin
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      start = 1'($urandom);
      model_step(m, si);
      tick();
      chk("q_step", q, mq);
      chk("so_step", serial_out, mso);
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("busy_off", busy, 0);
    chk("q_done", q, mq);
    if (!chain) begin
      tick();
      chk("done_once", done, 0);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_q", q, 0);
    chk("rst_so", serial_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_done", done, 0);

    do_load(8'h96);
    do_op(M_ASR, 3, 1'b0, 1'b0);
    chk("asr_final", q, 8'hF2);
    chk("asr_so", serial_out, 1);

    do_load(8'h81);
    do_op(M_ROL, 4, 1'b0, 1'b0);
    chk("rol_final", q, 8'h18);
    chk("rol_so", serial_out, 0);

    do_load(8'h00);
    do_op(M_SLI, 8, 1'b1, 1'b0);
    chk("sli_final", q, 8'hFF);

    do_load(8'hFF);
    mode = M_LSR;
    amount = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_step(M_LSR, 1'b0);
      tick();
      chk("lsr_q", q, mq);
    end
    chk("lsr_3f", q, 8'h3F);
    do_load(8'h5A);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_no_done", done, 0);
    chk("abort_q", q, 8'h5A);

    for (int m = 0; m < 8; m++) do_op(3'(m), 0, 1'b1, 1'b0);

    load_n = 1'b0;
    load_val = 8'hC3;
    start = 1'b1;
    tick();
    load_n = 1'b1;
    start = 1'b0;
    mq = 8'hC3;
    chk("ld_over_start_q", q, mq);
    chk("ld_over_start_busy", busy, 0);
    chk("ld_over_start_done", done, 0);

    mode = M_ROL;
    amount = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    load_n = 1'b0;
    start = 1'b1;
    tick();
    reset_n = 1'b1;
    load_n = 1'b1;
    start = 1'b0;
    mq = '0;
    mso = 1'b0;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_so", serial_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    tick();
    chk("mid_rst_no_done", done, 0);

    do_load(8'h01);
    do_op(M_LSL, 2, 1'b0, 1'b1);
    chk("b2b_first", q, 8'h04);
    do_op(M_LSL, 1, 1'b0, 1'b0);
    chk("b2b_second", q, 8'h08);

    for (int k = 0; k < 30; k++) begin
      do_load(W'($urandom));
      do_op(3'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
